// File: rtl/serial_char_tx.sv
// Serial character transmitter: 8N1 frames, LSB first, with a one-deep holding
// register in front of the shift register and a sticky overrun flag.
module serial_char_tx #(
  parameter int CYCLES_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       clear_overrun,
  output logic       data_out,
  output logic       ready,
  output logic       busy,
  output logic       char_sent,
  output logic       overrun,
  output logic [3:0] bic
);

  localparam logic [7:0] CNT_LAST = 8'(CYCLES_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [3:0] bic_q;
  logic [7:0] shift_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       data_out_q;
  logic       busy_q;
  logic       char_sent_q;
  logic       overrun_q;

  logic bit_end;
  logic drain_d;
  logic accept_d;
  logic ovr_set_d;

  // The holding register drains on the same edge the FSM enters START,
  // so a load in that cycle can refill it without being counted as overrun.
  always_comb begin
    bit_end   = (cnt_q == CNT_LAST);
    drain_d   = hold_full_q && ((state_q == IDLE) || (state_q == STOP && bit_end));
    accept_d  = load && (!hold_full_q || drain_d);
    ovr_set_d = load && hold_full_q && !drain_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bic_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      data_out_q  <= 1'b1;
      busy_q      <= 1'b0;
      char_sent_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      char_sent_q <= 1'b0;

      // A new overrun event wins over a simultaneous clear.
      if (clear_overrun) overrun_q <= 1'b0;
      if (ovr_set_d)     overrun_q <= 1'b1;

      if (drain_d) hold_full_q <= 1'b0;
      if (accept_d) begin
        hold_q      <= data_in;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          bic_q <= '0;
          if (hold_full_q) begin
            state_q    <= START;
            shift_q    <= hold_q;
            data_out_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q    <= DATA;
            cnt_q      <= '0;
            bic_q      <= 4'd1;
            data_out_q <= shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bic_q == 4'd8) begin
              state_q    <= STOP;
              bic_q      <= 4'd9;
              data_out_q <= 1'b1;
            end else begin
              bic_q      <= bic_q + 4'd1;
              data_out_q <= shift_q[0];
              shift_q    <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q       <= '0;
            bic_q       <= '0;
            char_sent_q <= 1'b1;
            if (hold_full_q) begin
              state_q    <= START;
              shift_q    <= hold_q;
              data_out_q <= 1'b0;
            end else begin
              state_q    <= IDLE;
              data_out_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ~hold_full_q;
  assign busy      = busy_q;
  assign char_sent = char_sent_q;
  assign overrun   = overrun_q;
  assign bic       = bic_q;

endmodule

// File: tb/tb_serial_char_tx.sv
// Directed bench for serial_char_tx: CPB=16 instance for framing, back-to-back,
// overrun and reset cases; CPB=2 instance for the minimum-parameter frame.
module tb_serial_char_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in, data_in2;
  logic       load, load2, clear_overrun, clear2;
  logic       data_out, ready, busy, char_sent, overrun;
  logic [3:0] bic;
  logic       data_out2, ready2, busy2, char_sent2, overrun2;
  logic [3:0] bic2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_char_tx #(.CYCLES_PER_BIT(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .clear_overrun(clear_overrun), .data_out(data_out), .ready(ready),
    .busy(busy), .char_sent(char_sent), .overrun(overrun), .bic(bic)
  );

  serial_char_tx #(.CYCLES_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset), .data_in(data_in2), .load(load2),
    .clear_overrun(clear2), .data_out(data_out2), .ready(ready2),
    .busy(busy2), .char_sent(char_sent2), .overrun(overrun2), .bic(bic2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after the edge that starts the frame (i=0); returns just after
  // the edge that ends the stop bit (i=160). Optionally pulses load/clear at act_at.
  task automatic run_frame(input string tag, input logic [9:0] line, input int act_at,
                           input logic [7:0] act_dat, input logic act_clr);
    int busy_bad = 0;
    int early_sent = 0;
    for (int i = 0; i < 160; i++) begin
      if (i % 16 == 8) begin
        chk($sformatf("%s bit%0d", tag, i / 16), data_out, line[i / 16]);
        chk($sformatf("%s bic%0d", tag, i / 16), bic, i / 16);
      end
      if (busy !== 1'b1) busy_bad++;
      if (i > 0 && char_sent !== 1'b0) early_sent++;
      if (i == act_at) begin
        load = 1'b1; data_in = act_dat; clear_overrun = act_clr;
      end else begin
        load = 1'b0; clear_overrun = 1'b0;
      end
      tick();
    end
    load = 1'b0; clear_overrun = 1'b0;
    chk({tag, " busy_in_frame"}, busy_bad, 0);
    chk({tag, " no_early_sent"}, early_sent, 0);
    chk({tag, " char_sent"}, char_sent, 1'b1);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load2 = 1'b0; clear_overrun = 1'b0; clear2 = 1'b0;
    data_in = '0; data_in2 = '0;
    #22;
    chk("rst data_out", data_out, 1'b1);
    chk("rst ready", ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst char_sent", char_sent, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst bic", bic, 4'd0);
    chk("rst2 data_out", data_out2, 1'b1);
    tick();
    reset = 1'b1;
    tick();

    // Single frame 0xA5
    load = 1'b1; data_in = 8'hA5;
    tick();
    load = 1'b0;
    chk("a5 ready_full", ready, 1'b0);
    chk("a5 busy_pre", busy, 1'b0);
    chk("a5 line_pre", data_out, 1'b1);
    tick();
    chk("a5 busy_start", busy, 1'b1);
    chk("a5 start_bit", data_out, 1'b0);
    chk("a5 ready_drained", ready, 1'b1);
    run_frame("a5", 10'b1101001010, -1, 8'h00, 1'b0);
    chk("a5 busy_after", busy, 1'b0);
    chk("a5 line_after", data_out, 1'b1);
    chk("a5 bic_after", bic, 4'd0);
    tick();
    chk("a5 sent_one_cycle", char_sent, 1'b0);

    // Back-to-back 0x3C then 0xC3 loaded mid-frame
    load = 1'b1; data_in = 8'h3C;
    tick();
    load = 1'b0;
    tick();
    run_frame("3c", 10'b1001111000, 40, 8'hC3, 1'b0);
    chk("b2b busy_contig", busy, 1'b1);
    chk("b2b next_start", data_out, 1'b0);
    run_frame("c3", 10'b1110000110, -1, 8'h00, 1'b0);
    chk("b2b busy_after", busy, 1'b0);
    chk("b2b no_overrun", overrun, 1'b0);
    tick();

    // Overrun: 0x11, 0x22, 0x33 in consecutive cycles
    load = 1'b1; data_in = 8'h11;
    tick();
    data_in = 8'h22;
    tick();
    chk("ovr before", overrun, 1'b0);
    run_frame("11", 10'b1000100010, 0, 8'h33, 1'b0);
    chk("ovr set", overrun, 1'b1);
    run_frame("22", 10'b1001000100, -1, 8'h00, 1'b0);
    chk("ovr 33_dropped", busy, 1'b0);
    chk("ovr sticky", overrun, 1'b1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr cleared", overrun, 1'b0);

    // Load in the draining stop-bit cycle; then overrun with simultaneous clear
    load = 1'b1; data_in = 8'h55;
    tick();
    data_in = 8'h0F;
    tick();
    run_frame("55", 10'b1010101010, 159, 8'hF0, 1'b0);
    chk("drain ready_refilled", ready, 1'b0);
    chk("drain no_overrun", overrun, 1'b0);
    run_frame("0f", 10'b1000011110, 40, 8'hAA, 1'b1);
    chk("clr_vs_set overrun", overrun, 1'b1);
    run_frame("f0", 10'b1111100000, -1, 8'h00, 1'b0);
    chk("drain busy_after", busy, 1'b0);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("drain ovr_cleared", overrun, 1'b0);

    // Reset in the middle of bit 4 of 0xFF
    load = 1'b1; data_in = 8'hFF;
    tick();
    load = 1'b0;
    tick();
    repeat (72) tick();
    chk("rstmid bic_before", bic, 4'd4);
    chk("rstmid busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid line_async", data_out, 1'b1);
    chk("rstmid busy_async", busy, 1'b0);
    chk("rstmid ready_async", ready, 1'b1);
    chk("rstmid bic_async", bic, 4'd0);
    chk("rstmid no_sent", char_sent, 1'b0);
    tick();
    tick();
    reset = 1'b1; load = 1'b1; data_in = 8'h00;
    tick();
    load = 1'b0;
    chk("rstmid first_edge_load", ready, 1'b0);
    tick();
    chk("rstmid 00_start", busy, 1'b1);
    run_frame("00", 10'b1000000000, -1, 8'h00, 1'b0);
    chk("rstmid busy_after", busy, 1'b0);
    tick();

    // Minimum parameter: CPB=2, 0x80
    begin
      logic [9:0] line2;
      line2 = 10'b1100000000;
      load2 = 1'b1; data_in2 = 8'h80;
      tick();
      load2 = 1'b0;
      tick();
      for (int i = 0; i <= 20; i++) begin
        chk($sformatf("cpb2 bic i%0d", i), bic2, (i < 20) ? i / 2 : 0);
        chk($sformatf("cpb2 line i%0d", i), data_out2, (i < 20) ? line2[i / 2] : 1'b1);
        chk($sformatf("cpb2 sent i%0d", i), char_sent2, (i == 20) ? 1'b1 : 1'b0);
        if (i < 20) tick();
      end
      chk("cpb2 busy_after", busy2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_char_tx.md
SERIAL_CHAR_TX -- requirements
Module: serial_char_tx

Interface
REQ-001 SHALL have parameter CYCLES_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_in  input  8  character to transmit, sampled when load is accepted.
REQ-005 SHALL have port load  input  1  one-cycle write strobe from the microprocessor PIO.
REQ-006 SHALL have port clear_overrun  input  1  synchronous clear of the overrun flag.
REQ-007 SHALL have port data_out  output  1  serial line, idle high, to GPIO.
REQ-008 SHALL have port ready  output  1  high when the holding register is empty.
REQ-009 SHALL have port busy  output  1  high while a frame is on the line.
REQ-010 SHALL have port char_sent  output  1  one-cycle pulse after each stop bit completes.
REQ-011 SHALL have port overrun  output  1  sticky flag: a character was dropped.
REQ-012 SHALL have port bic  output  4  current bit index, 0 = start, 1-8 = data, 9 = stop.

Function
REQ-013 Frame format SHALL be: start bit 0; data_in[0] through data_in[7], LSB first; stop bit 1. Total 10 bits, no parity.
REQ-014 Each bit SHALL hold data_out stable for exactly CYCLES_PER_BIT cycles, timed by an internal sample counter. A frame SHALL last exactly 10*CYCLES_PER_BIT cycles.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE->START when the holding register is full.
- START->DATA after one bit time.
- DATA->STOP after the 8th data bit time.
- STOP->START if the holding register is full at stop-bit end; otherwise STOP->IDLE.
REQ-016 data_out SHALL be registered.
- Load accepted in cycle N while IDLE with holding empty: holding fills at edge N+1, the start bit appears at edge N+2, busy=1 from edge N+2.
REQ-017 The holding register SHALL be one character deep.
- load is accepted when ready=1, or when the shifter drains the holding register in the same cycle.
- Data moves holding->shifter on the IDLE->START or STOP->START transition.
REQ-018 ready SHALL equal NOT(holding full), registered.
REQ-019 load when holding is full and not draining that cycle: data_in SHALL be discarded, holding and shifter SHALL be unchanged, and overrun SHALL be set from the next edge.
REQ-020 overrun SHALL stay set until clear_overrun=1 or reset.
- clear_overrun and a new overrun event in the same cycle: overrun SHALL remain 1.
REQ-021 char_sent SHALL pulse high for exactly one cycle, on the edge where the stop bit's last cycle ends, including back-to-back frames.
REQ-022 Back-to-back frames SHALL have zero idle cycles between the stop bit and the next start bit.
REQ-023 bic SHALL read 0 in IDLE and START, 1-8 in DATA, 9 in STOP.
REQ-024 load while busy with holding empty SHALL NOT disturb the frame currently on the line.
REQ-025 The sample counter SHALL reset to 0 at every bit boundary. Counter width SHALL be 8 bits, and no counter SHALL wrap mid-bit.

Reset
REQ-026 reset=0 SHALL immediately force: data_out=1, ready=1, busy=0, char_sent=0, overrun=0, bic=0, FSM=IDLE, holding empty, counters 0.
REQ-027 reset asserted mid-frame SHALL abort the frame. The line SHALL go high immediately, and the partial character SHALL be lost with no char_sent pulse.
REQ-028 After reset deasserts, the first edge SHALL behave as IDLE; a load on that edge SHALL be accepted.

Verification
REQ-029 Single frame: CPB=16, load 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; char_sent pulses once at frame cycle 160; busy=0 afterwards.
REQ-030 Back-to-back: load 0x3C, then load 0xC3 mid-frame -> 320 contiguous frame cycles; two char_sent pulses 160 cycles apart; no overrun.
REQ-031 Overrun: load 0x11, 0x22, 0x33 in three consecutive cycles -> 0x11 and 0x22 are sent, 0x33 is dropped, overrun=1.
- Then clear_overrun=1 for one cycle -> overrun=0.
REQ-032 Reset mid-frame: assert reset at bit 4 of 0xFF -> data_out=1 and busy=0 without waiting for a clock edge; no char_sent pulse.
- Then load 0x00 -> one clean frame is sent.
REQ-033 Boundary: load exactly in the char_sent cycle with holding full draining -> the new character is accepted, overrun stays 0.
REQ-034 Minimum parameter: CPB=2, load 0x80 -> frame lasts 20 cycles; bic sequence 0,1..8,9,0.
